// File: rtl/bcd_arb_pkg.sv
// Shared types and constants for the BCD converter arbiter: state encoding,
// digit/result widths, default watchdog limit and an id-width helper.
package bcd_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam int DIGIT_W                = 4;
  localparam int RESULT_W               = 3 * DIGIT_W;
  localparam int DEFAULT_TIMEOUT_CYCLES = 64;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bcd_conv_arbiter_if.sv
// Requester-side bus of the BCD converter arbiter: request levels, operands,
// grant/response pulses and the returned digits.
interface bcd_conv_arbiter_if #(
  parameter int N_REQ = 2
);
  import bcd_arb_pkg::*;

  logic [N_REQ-1:0]    req;
  logic [8*N_REQ-1:0]  req_data;
  logic [N_REQ-1:0]    gnt;
  logic [N_REQ-1:0]    rsp_valid;
  logic [RESULT_W-1:0] rsp_digits;
  logic                rsp_ok;

  modport master (
    output req, req_data,
    input  gnt, rsp_valid, rsp_digits, rsp_ok
  );

  modport slave (
    input  req, req_data,
    output gnt, rsp_valid, rsp_digits, rsp_ok
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request bit searching upward
// from (last+1) mod N_REQ with wrap-around.
module rr_arbiter
  import bcd_arb_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0]              req,
  input  logic [id_width(N_REQ)-1:0]    last,
  output logic [N_REQ-1:0]              grant,
  output logic [id_width(N_REQ)-1:0]    id
);

  localparam int IDW = id_width(N_REQ);

  logic found;
  int   idx;

  always_comb begin
    grant = '0;
    id    = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = int'(last) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        id         = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Shares one bcd_converter between N_REQ requesters (round-robin).
// Optional WAIT watchdog enabled by defining BCD_ARB_TIMEOUT_EN.
module bcd_conv_arbiter
  import bcd_arb_pkg::*;
#(
  parameter int N_REQ          = 2,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                clk,
  input  logic                reset,
  bcd_conv_arbiter_if.slave   rq,
  output logic                busy,
  output logic                bcd_start,
  output logic [7:0]          bcd_a,
  input  logic                bcd_done,
  input  logic                bcd_valid,
  input  logic [RESULT_W-1:0] bcd_digits
);

  localparam int IDW = id_width(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("bcd_conv_arbiter: N_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  arb_state_t       state;
  logic [IDW-1:0]   last;
  logic [IDW-1:0]   id;
  logic [N_REQ-1:0] pick_gnt;
  logic [IDW-1:0]   pick_id;

`ifdef BCD_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_cnt;
`endif

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req   (rq.req),
    .last  (last),
    .grant (pick_gnt),
    .id    (pick_id)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      last          <= IDW'(N_REQ - 1);
      id            <= '0;
      busy          <= 1'b0;
      bcd_start     <= 1'b0;
      bcd_a         <= '0;
      rq.gnt        <= '0;
      rq.rsp_valid  <= '0;
      rq.rsp_digits <= '0;
      rq.rsp_ok     <= 1'b0;
`ifdef BCD_ARB_TIMEOUT_EN
      wait_cnt      <= '0;
`endif
    end else begin
      rq.gnt       <= '0;
      rq.rsp_valid <= '0;
      bcd_start    <= 1'b0;
      case (state)
        IDLE: begin
          if (|rq.req) begin
            id     <= pick_id;
            last   <= pick_id;
            bcd_a  <= rq.req_data[8*int'(pick_id) +: 8];
            rq.gnt <= pick_gnt;
            busy   <= 1'b1;
            state  <= START;
          end
        end
        START: begin
          bcd_start <= 1'b1;
          state     <= WAIT;
`ifdef BCD_ARB_TIMEOUT_EN
          wait_cnt  <= '0;
`endif
        end
        WAIT: begin
          if (bcd_done) begin
            rq.rsp_digits <= bcd_digits;
            rq.rsp_ok     <= bcd_valid;
            rq.rsp_valid  <= N_REQ'(1) << id;
            state         <= RESP;
          end
`ifdef BCD_ARB_TIMEOUT_EN
          // Watchdog: the last of TIMEOUT_CYCLES WAIT cycles forces an error response.
          else if (wait_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            rq.rsp_digits <= '0;
            rq.rsp_ok     <= 1'b0;
            rq.rsp_valid  <= N_REQ'(1) << id;
            state         <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed bench for bcd_conv_arbiter with a 4-cycle converter model.
module tb_bcd_conv_arbiter;
  import bcd_arb_pkg::*;

  localparam int N = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        busy, bcd_start, bcd_done, bcd_valid;
  logic [7:0]  bcd_a;
  logic [11:0] bcd_digits;

  always #5 clk = ~clk;

  bcd_conv_arbiter_if #(.N_REQ(N)) rq ();

  bcd_conv_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .rq         (rq),
    .busy       (busy),
    .bcd_start  (bcd_start),
    .bcd_a      (bcd_a),
    .bcd_done   (bcd_done),
    .bcd_valid  (bcd_valid),
    .bcd_digits (bcd_digits)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // converter model: done 4 cycles after start, valid=0 for operand 200
  int         mdl_cnt = 0;
  logic [7:0] mdl_a = '0;
  bit         mdl_mute = 1'b0;

  initial begin
    bcd_done   = 1'b0;
    bcd_valid  = 1'b0;
    bcd_digits = '0;
    forever begin
      @(negedge clk);
      bcd_done = 1'b0;
      if (mdl_cnt > 0) begin
        mdl_cnt--;
        if (mdl_cnt == 0 && !mdl_mute) begin
          bcd_done   = 1'b1;
          bcd_valid  = (mdl_a != 8'd200);
          bcd_digits = {4'(mdl_a / 100), 4'((mdl_a / 10) % 10), 4'(mdl_a % 10)};
        end
      end
      if (bcd_start) begin
        mdl_a   = bcd_a;
        mdl_cnt = 4;
      end
    end
  end

  int gnt_cnt [N];
  int rsp_cnt [N];
  int onehot_viol = 0;

  initial begin
    for (int i = 0; i < N; i++) begin
      gnt_cnt[i] = 0;
      rsp_cnt[i] = 0;
    end
  end

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (rq.gnt[i] === 1'b1) gnt_cnt[i]++;
      if (rq.rsp_valid[i] === 1'b1) rsp_cnt[i]++;
    end
    if ($countones(rq.gnt) > 1 || $countones(rq.rsp_valid) > 1) onehot_viol++;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    rq.req = '0;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic await_gnt(input logic [N-1:0] exp, input string tag, input bit drop, output int lat);
    lat = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      lat++;
      if (rq.gnt != '0) break;
    end
    check(tag, 32'(rq.gnt), 32'(exp));
    if (drop) rq.req = rq.req & ~exp;
  endtask

  task automatic await_rsp(input logic [N-1:0] exp, input logic [11:0] dig, input bit ok,
                           input string tag, output int lat);
    lat = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      lat++;
      if (rq.rsp_valid != '0) break;
    end
    check({tag, "_valid"}, 32'(rq.rsp_valid), 32'(exp));
    check({tag, "_digits"}, 32'(rq.rsp_digits), 32'(dig));
    check({tag, "_ok"}, 32'(rq.rsp_ok), 32'(ok));
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int lat, t, g1, r1, r0;
    rq.req      = '0;
    rq.req_data = '0;
    tick(3);
    check("rst_busy", 32'(busy), 0);
    check("rst_gnt", 32'(rq.gnt), 0);
    check("rst_rsp_valid", 32'(rq.rsp_valid), 0);
    check("rst_start", 32'(bcd_start), 0);
    check("rst_bcd_a", 32'(bcd_a), 0);
    check("rst_rsp", 32'({rq.rsp_ok, rq.rsp_digits}), 0);
    reset = 1'b0;

    // single request, full latency
    tick();
    rq.req      = 2'b01;
    rq.req_data = {8'd0, 8'd255};
    await_gnt(2'b01, "t1_gnt", 1'b1, lat);
    check("t1_gnt_lat", 32'(lat), 1);
    check("t1_busy", 32'(busy), 1);
    tick();
    check("t1_start", 32'(bcd_start), 1);
    check("t1_bcd_a", 32'(bcd_a), 255);
    check("t1_gnt_pulse", 32'(rq.gnt), 0);
    await_rsp(2'b01, 12'h255, 1'b1, "t1_rsp", lat);
    check("t1_total_lat", 32'(lat + 2), 7);
    tick();
    check("t1_rsp_pulse", 32'(rq.rsp_valid), 0);
    check("t1_idle_busy", 32'(busy), 0);
    check("t1_start_pulse", 32'(bcd_start), 0);

    // contention from reset
    do_reset();
    rq.req      = 2'b11;
    rq.req_data = {8'd128, 8'd7};
    await_gnt(2'b01, "c1_gnt0", 1'b1, lat);
    await_rsp(2'b01, 12'h007, 1'b1, "c1_rsp0", lat);
    await_gnt(2'b10, "c1_gnt1", 1'b1, lat);
    check("c1_gnt1_lat", 32'(lat), 2);
    await_rsp(2'b10, 12'h128, 1'b1, "c1_rsp1", lat);
    rq.req = 2'b11;
    await_gnt(2'b01, "c2_gnt0", 1'b1, lat);
    await_rsp(2'b01, 12'h007, 1'b1, "c2_rsp0", lat);
    await_gnt(2'b10, "c2_gnt1", 1'b1, lat);
    await_rsp(2'b10, 12'h128, 1'b1, "c2_rsp1", lat);
    rq.req      = 2'b10;
    rq.req_data = {8'd99, 8'd7};
    await_gnt(2'b10, "c3_gnt1_again", 1'b1, lat);
    check("c3_gnt_lat", 32'(lat), 2);
    await_rsp(2'b10, 12'h099, 1'b1, "c3_rsp1", lat);

    // invalid converter result
    tick();
    r0 = rsp_cnt[0];
    rq.req      = 2'b01;
    rq.req_data = {8'd0, 8'd200};
    await_gnt(2'b01, "inv_gnt", 1'b1, lat);
    await_rsp(2'b01, 12'h200, 1'b0, "inv_rsp", lat);
    tick(3);
    check("inv_rsp_once", 32'(rsp_cnt[0] - r0), 1);

    // reset two cycles after bcd_start
    rq.req      = 2'b01;
    rq.req_data = {8'd0, 8'd42};
    await_gnt(2'b01, "r_gnt", 1'b0, lat);
    tick();
    check("r_start", 32'(bcd_start), 1);
    tick(2);
    reset = 1'b1;
    tick();
    check("r_busy", 32'(busy), 0);
    check("r_outs", 32'({rq.gnt, rq.rsp_valid, bcd_start, rq.rsp_ok}), 0);
    check("r_bcd_a", 32'(bcd_a), 0);
    check("r_digits", 32'(rq.rsp_digits), 0);
    r0 = rsp_cnt[0];
    reset = 1'b0;
    await_gnt(2'b01, "r_regnt", 1'b1, lat);
    check("r_regnt_lat", 32'(lat), 1);
    tick();
    check("r_no_stale_rsp", 32'(rsp_cnt[0] - r0), 0);
    await_rsp(2'b01, 12'h042, 1'b1, "r_rsp", lat);
    check("r_rsp_lat", 32'(lat), 5);

    // withdrawn request while busy
    tick();
    g1 = gnt_cnt[1];
    r1 = rsp_cnt[1];
    rq.req      = 2'b01;
    rq.req_data = {8'd77, 8'd5};
    await_gnt(2'b01, "w_gnt0", 1'b1, lat);
    tick(2);
    rq.req[1] = 1'b1;
    tick(2);
    rq.req[1] = 1'b0;
    await_rsp(2'b01, 12'h005, 1'b1, "w_rsp0", lat);
    tick(5);
    check("w_no_gnt1", 32'(gnt_cnt[1] - g1), 0);
    check("w_no_rsp1", 32'(rsp_cnt[1] - r1), 0);
    check("w_idle", 32'(busy), 0);

    // converter never answers
    mdl_mute    = 1'b1;
    rq.req      = 2'b01;
    rq.req_data = {8'd0, 8'd9};
    r0 = rsp_cnt[0];
    await_gnt(2'b01, "to_gnt", 1'b1, lat);
    tick();
`ifdef BCD_ARB_TIMEOUT_EN
    t = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      t++;
      if (rq.rsp_valid != '0) break;
    end
    check("to_wait_cycles", 32'(t), 64);
    check("to_valid", 32'(rq.rsp_valid), 32'(2'b01));
    check("to_ok", 32'(rq.rsp_ok), 0);
    check("to_digits", 32'(rq.rsp_digits), 0);
`else
    t = 0;
    tick(150);
    check("to_busy_held", 32'(busy), 1);
    check("to_no_rsp", 32'(rsp_cnt[0] - r0), 0);
    do_reset();
    check("to_reset_busy", 32'(busy), 0);
`endif
    mdl_mute = 1'b0;
    tick(3);

    check("onehot", 32'(onehot_viol), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/bcd_conv_arbiter.md
Name: bcd_conv_arbiter

Overview:
- Shares one bcd_converter instance between N_REQ requesters, e.g. the CPU-side peripheral wrapper and a display-refresh scanner in the calculator SoC.
- Arbitrates requests round-robin, latches the operand and pulses the converter start.
- Waits for done, then returns the three BCD digits and the converter's valid flag to the winning requester.
- Sits between the requester peripherals and the bcd_converter ports start/A/done/valid/X/X_prime/X_prime_prime.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- TIMEOUT_CYCLES, 64, watchdog limit in cycles while waiting for done. Used only with the optional feature.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req  in  N_REQ  per-requester request level.
- req_data  in  8*N_REQ  operands; requester i drives bits [8i+7:8i].
- gnt  out  N_REQ  one-cycle pulse: request i accepted and its operand latched.
- rsp_valid  out  N_REQ  one-cycle pulse: result ready for requester i.
- rsp_digits  out  12  {hundreds, tens, units}; meaningful only while any rsp_valid bit is high.
- rsp_ok  out  1  converter valid flag, qualified by rsp_valid.
- busy  out  1  high in every state except IDLE.
- bcd_start  out  1  start pulse to the converter.
- bcd_a  out  8  operand to the converter.
- bcd_done  in  1  converter done.
- bcd_valid  in  1  converter valid.
- bcd_digits  in  12  {X_prime_prime, X_prime, X}.

Behaviour:
Reset and clocking:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset values: all outputs 0; state IDLE; last-grant pointer = N_REQ-1, so requester 0 wins first.

FSM states IDLE, START, WAIT, RESP:
- IDLE:
  - If req is non-zero, pick the first set bit searching from (last+1) mod N_REQ upward with wrap-around.
  - Register the winner id, latch bcd_a from its req_data, pulse gnt[id] for 1 cycle, update last, go to START.
  - If req is zero, stay in IDLE.
- START:
  - bcd_start=1 for exactly this cycle; bcd_a holds the latched operand. Go to WAIT.
- WAIT:
  - bcd_start=0. Sample bcd_done each cycle.
  - On done=1, capture bcd_digits and bcd_valid, then go to RESP.
  - bcd_done is ignored in all other states.
- RESP:
  - rsp_valid[id]=1 for 1 cycle with rsp_digits and rsp_ok registered. Go to IDLE.
  - A new grant can occur in the following IDLE cycle.

Handshake:
- A requester holds req and req_data stable until it sees gnt.
- The requester must drop req the cycle after gnt; a req still high in IDLE counts as a new request.
- Dropping req before gnt withdraws it silently.
- Requests arriving while busy wait; they are not queued separately.

Latency and fairness:
- req to gnt: 1 cycle. gnt to bcd_start: 1 cycle. done to rsp_valid: 1 cycle.
- Total latency = converter latency + 3 cycles.
- Simultaneous requests are served in rotating order; no requester waits more than N_REQ-1 conversions.

Other rules:
- bcd_a is held constant from START until leaving RESP.
- Reset during any state returns to IDLE within the same edge. No rsp_valid or bcd_start is emitted, and the pending result is lost.
- At most one bit of gnt or rsp_valid is high in any cycle.

Optional Feature:
- Macro: BCD_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entering WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES without done, go to RESP with rsp_ok=0 and rsp_digits=12'h000.
  - The counter width is sized for TIMEOUT_CYCLES.
- Not defined: no counter; WAIT lasts until done, even indefinitely.

Decomposition:
- Package bcd_arb_pkg contains:
  - the state encoding (IDLE=0, START=1, WAIT=2, RESP=3);
  - the digit-width constant (4) and the result-width constant (12);
  - the default TIMEOUT_CYCLES.
- Sub-module rr_arbiter (parameter N_REQ) holds the round-robin pick.
  - Inputs: req, last pointer.
  - Outputs: one-hot grant vector and encoded id; combinational, no state.
  - The FSM, latches and pointer register stay in bcd_conv_arbiter.

Test Plan:
- Single request: req[0] with data 8'd255; converter model done after 4 cycles with valid=1 -> gnt[0] one cycle later, bcd_start one cycle later, rsp_valid[0] with rsp_digits=12'h255 and rsp_ok=1, total 7 cycles.
- Contention: req=2'b11 from reset with data 8'd7 and 8'd128 -> gnt[0] first with result 12'h007; then gnt[1] with result 12'h128. A second contention round starts with gnt[0] again because last=1. Requester 1 alone re-requesting immediately after its own service is granted.
- Invalid result: converter returns valid=0 for operand 8'd200 -> rsp_ok=0, rsp_valid still pulses once.
- Reset mid-WAIT: assert reset 2 cycles after bcd_start -> next cycle busy=0 and all outputs 0; no rsp_valid even if done arrives later. req held high -> fresh grant to requester 0.
- Timeout, with BCD_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=64: bcd_done tied low -> rsp_valid exactly 64 WAIT cycles after entry, rsp_ok=0, rsp_digits=0. Without the macro, busy stays high.
- Withdrawn request: raise req[1] while busy, drop it before the conversion finishes -> no gnt[1] and no rsp_valid[1].
